// File: rtl/sonar_pkg.sv
// ============================================================================
// Module : sonar_pkg
// Brief  : Shared states, ASCII constants and BCD sentinel for the sonar sweep.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sonar_pkg;

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        POSICIONA = 4'd1,
        MEDE      = 4'd2,
        ESPERA    = 4'd3,
        ACUMULA   = 4'd4,
        TX        = 4'd5,
        PROXIMO   = 4'd6,
        FIM       = 4'd7
    } estado_t;

    localparam logic [6:0]  ASCII_VIRGULA    = 7'h2C;
    localparam logic [6:0]  ASCII_CERQUILHA  = 7'h23;
    localparam logic [6:0]  ASCII_EXCLAMACAO = 7'h21;
    localparam logic [6:0]  ASCII_ZERO       = 7'h30;
    localparam logic [11:0] SEM_ECO          = 12'h999;
    localparam logic [2:0]  ULTIMO_BYTE      = 3'd5;

    // 7'h37 + 10 lands on 'A'
    function automatic logic [6:0] hex_ascii(input logic [3:0] v);
        return (v < 4'd10) ? (ASCII_ZERO + {3'b000, v}) : (7'h37 + {3'b000, v});
    endfunction

endpackage

`default_nettype wire

// File: rtl/contador_m.sv
// ============================================================================
// Module : contador_m
// Brief  : Modulo-M up counter with synchronous clear; o_fim flags the last count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module contador_m #(
    parameter int M = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic i_zera,
    input  logic i_conta,
    output logic o_fim
);

    localparam int         W        = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] c_ULTIMO = W'(M - 1);

    logic [W-1:0] r_q;

    always_ff @(posedge clock) begin
        if (!reset || i_zera) begin
            r_q <= '0;
        end else if (i_conta) begin
            r_q <= (r_q == c_ULTIMO) ? '0 : r_q + 1'b1;
        end
    end

    assign o_fim = i_conta && (r_q == c_ULTIMO);

endmodule

`default_nettype wire

// File: rtl/sonar_frame_ascii.sv
// ============================================================================
// Module : sonar_frame_ascii
// Brief  : Selects the ASCII byte of the 6-byte "P,DDDx" frame by byte index.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sonar_frame_ascii
    import sonar_pkg::*;
#(
    parameter int W_POS = 3
) (
    input  logic [2:0]       i_indice_byte,
    input  logic [W_POS-1:0] i_posicao,
    input  logic [11:0]      i_distancia_min,
    input  logic             i_alerta,
    output logic [6:0]       o_dado_tx
);

    logic [3:0] w_pos_hex;

    always_comb begin
        w_pos_hex = 4'(i_posicao);
        o_dado_tx = ASCII_ZERO;
        case (i_indice_byte)
            3'd0:    o_dado_tx = hex_ascii(w_pos_hex);
            3'd1:    o_dado_tx = ASCII_VIRGULA;
            3'd2:    o_dado_tx = ASCII_ZERO + {3'b000, i_distancia_min[11:8]};
            3'd3:    o_dado_tx = ASCII_ZERO + {3'b000, i_distancia_min[7:4]};
            3'd4:    o_dado_tx = ASCII_ZERO + {3'b000, i_distancia_min[3:0]};
            3'd5:    o_dado_tx = i_alerta ? ASCII_EXCLAMACAO : ASCII_CERQUILHA;
            default: o_dado_tx = ASCII_ZERO;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sonar_varredura_param.sv
// ============================================================================
// Module : sonar_varredura_param
// Brief  : Servo sweep sequencer: settle, N measurements, keep min, send frame.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sonar_varredura_param
    import sonar_pkg::*;
#(
    parameter int          N_POS      = 8,
    parameter int          T_ASSENTAR = 25_000_000,
    parameter int          N_AMOSTRAS = 4,
    parameter int          T_TIMEOUT  = 2_500_000,
    parameter logic [11:0] LIMIAR     = 12'h020
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       ligar,
    input  logic                       modo_continuo,
    input  logic                       pronto_medida,
    input  logic [11:0]                distancia,
    input  logic                       pronto_tx,
    output logic                       medir,
    output logic                       partida_tx,
    output logic [6:0]                 dado_tx,
    output logic [$clog2(N_POS)-1:0]   posicao,
    output logic [11:0]                distancia_min,
    output logic                       alerta,
    output logic                       fim_posicao,
    output logic                       fim_varredura,
    output logic                       ocupado,
    output logic [3:0]                 db_estado
);

    localparam int W_POS  = $clog2(N_POS);
    localparam int W_CONT = $clog2(N_AMOSTRAS + 1);
    localparam int M_ASSENTAR = (T_ASSENTAR < 1) ? 1 : T_ASSENTAR;
    localparam int M_TIMEOUT  = (T_TIMEOUT  < 1) ? 1 : T_TIMEOUT;

    estado_t            r_estado;
    estado_t            w_proximo;
    logic [W_POS-1:0]   r_posicao;
    logic               r_desce;
    logic [W_CONT-1:0]  r_cont;
    logic [11:0]        r_min;
    logic [11:0]        r_amostra;
    logic [11:0]        r_dist_min;
    logic               r_alerta;
    logic [2:0]         r_indice;
    logic               r_aguarda;

    logic               w_fim_assentar;
    logic               w_fim_timeout;
    logic               w_ultima_amostra;
    logic               w_ultima_pos;
    logic [11:0]        w_novo_min;

    contador_m #(.M(M_ASSENTAR)) u_assentar (
        .clock   (clock),
        .reset   (reset),
        .i_zera  (r_estado != POSICIONA),
        .i_conta (1'b1),
        .o_fim   (w_fim_assentar)
    );

    contador_m #(.M(M_TIMEOUT)) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .i_zera  (r_estado != ESPERA),
        .i_conta (1'b1),
        .o_fim   (w_fim_timeout)
    );

    sonar_frame_ascii #(.W_POS(W_POS)) u_frame (
        .i_indice_byte   (r_indice),
        .i_posicao       (r_posicao),
        .i_distancia_min (r_dist_min),
        .i_alerta        (r_alerta),
        .o_dado_tx       (dado_tx)
    );

    assign w_ultima_amostra = (r_cont == W_CONT'(N_AMOSTRAS - 1));
    assign w_ultima_pos     = (r_posicao == W_POS'(N_POS - 1));
    assign w_novo_min       = (r_amostra < r_min) ? r_amostra : r_min;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_comb begin
        w_proximo     = r_estado;
        medir         = 1'b0;
        partida_tx    = 1'b0;
        fim_posicao   = 1'b0;
        fim_varredura = 1'b0;
        case (r_estado)
            INICIAL: begin
                if (ligar) w_proximo = POSICIONA;
            end
            POSICIONA: begin
                if (!ligar)              w_proximo = INICIAL;
                else if (w_fim_assentar) w_proximo = MEDE;
            end
            MEDE: begin
                medir     = ligar;
                w_proximo = ligar ? ESPERA : INICIAL;
            end
            ESPERA: begin
                if (!ligar)                              w_proximo = INICIAL;
                else if (pronto_medida || w_fim_timeout) w_proximo = ACUMULA;
            end
            ACUMULA: begin
                if (!ligar)                w_proximo = INICIAL;
                else if (w_ultima_amostra) w_proximo = TX;
                else                       w_proximo = MEDE;
            end
            TX: begin
                // An in-flight byte always completes; abort only between bytes.
                if (r_aguarda) begin
                    if (pronto_tx) begin
                        if (!ligar)                         w_proximo = INICIAL;
                        else if (r_indice == ULTIMO_BYTE)   w_proximo = PROXIMO;
                    end
                end else if (!ligar) begin
                    w_proximo = INICIAL;
                end else begin
                    partida_tx = 1'b1;
                end
            end
            PROXIMO: begin
                fim_posicao = 1'b1;
                if (!ligar) begin
                    w_proximo = INICIAL;
                end else if (!modo_continuo && w_ultima_pos) begin
                    fim_varredura = 1'b1;
                    w_proximo     = FIM;
                end else begin
                    w_proximo = POSICIONA;
                end
            end
            FIM: begin
                if (!ligar) w_proximo = INICIAL;
            end
            default: w_proximo = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_posicao  <= '0;
            r_desce    <= 1'b0;
            r_cont     <= '0;
            r_min      <= SEM_ECO;
            r_amostra  <= SEM_ECO;
            r_dist_min <= SEM_ECO;
            r_alerta   <= 1'b0;
            r_indice   <= '0;
            r_aguarda  <= 1'b0;
        end else begin
            case (r_estado)
                POSICIONA: r_min <= SEM_ECO;
                ESPERA: begin
                    if (pronto_medida)      r_amostra <= distancia;
                    else if (w_fim_timeout) r_amostra <= SEM_ECO;
                end
                ACUMULA: begin
                    if (w_proximo == TX) begin
                        r_dist_min <= w_novo_min;
                        r_alerta   <= (w_novo_min < LIMIAR);
                        r_cont     <= '0;
                    end else if (w_proximo == MEDE) begin
                        r_min  <= w_novo_min;
                        r_cont <= r_cont + 1'b1;
                    end
                end
                TX: begin
                    if (partida_tx) begin
                        r_aguarda <= 1'b1;
                    end else if (r_aguarda && pronto_tx) begin
                        r_aguarda <= 1'b0;
                        r_indice  <= r_indice + 1'b1;
                    end
                end
                PROXIMO: begin
                    r_indice <= '0;
                    if (w_proximo == POSICIONA) begin
                        if (!modo_continuo) begin
                            r_posicao <= r_posicao + 1'b1;
                            r_desce   <= 1'b0;
                        end else if (!r_desce) begin
                            if (w_ultima_pos) begin
                                r_desce   <= 1'b1;
                                r_posicao <= r_posicao - 1'b1;
                            end else begin
                                r_posicao <= r_posicao + 1'b1;
                            end
                        end else if (r_posicao == '0) begin
                            r_desce   <= 1'b0;
                            r_posicao <= r_posicao + 1'b1;
                        end else begin
                            r_posicao <= r_posicao - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            // Any return to idle restarts the sweep from position 0 going up.
            if (w_proximo == INICIAL) begin
                r_posicao <= '0;
                r_desce   <= 1'b0;
                r_cont    <= '0;
                r_indice  <= '0;
                r_aguarda <= 1'b0;
            end
        end
    end

    assign posicao       = r_posicao;
    assign distancia_min = r_dist_min;
    assign alerta        = r_alerta;
    assign ocupado       = (r_estado != INICIAL) && (r_estado != FIM);
    assign db_estado     = r_estado;

endmodule

`default_nettype wire

// File: tb/tb_sonar_varredura_param.sv
// ============================================================================
// Module : tb_sonar_varredura_param
// Brief  : Directed bench with measurement-unit and serial-TX responders.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sonar_varredura_param;

    localparam int          c_RESP_ECO = 3;
    localparam int          c_RESP_TX  = 3;

    logic        clk = 1'b0;
    logic        reset, ligar, modo_continuo, pronto_medida, pronto_tx;
    logic [11:0] distancia;
    logic        medir, partida_tx, alerta, fim_posicao, fim_varredura, ocupado;
    logic [6:0]  dado_tx;
    logic [1:0]  posicao;
    logic [11:0] distancia_min;
    logic [3:0]  db_estado;

    always #5 clk = ~clk;

    sonar_varredura_param #(
        .N_POS(3), .T_ASSENTAR(4), .N_AMOSTRAS(2), .T_TIMEOUT(20), .LIMIAR(12'h020)
    ) dut (
        .clock(clk), .reset(reset), .ligar(ligar), .modo_continuo(modo_continuo),
        .pronto_medida(pronto_medida), .distancia(distancia), .pronto_tx(pronto_tx),
        .medir(medir), .partida_tx(partida_tx), .dado_tx(dado_tx), .posicao(posicao),
        .distancia_min(distancia_min), .alerta(alerta), .fim_posicao(fim_posicao),
        .fim_varredura(fim_varredura), .ocupado(ocupado), .db_estado(db_estado)
    );

    // Stimulus knobs written only by the main process.
    logic        eco_on;
    logic [11:0] amostra_a, amostra_b;
    int          medir_base;

    // Responder bookkeeping written only by the responder process.
    logic [6:0]  byte_mem [0:255];
    logic [1:0]  pos_mem  [0:255];
    int          n_bytes = 0, n_medir = 0, n_fim_pos = 0, n_fim_var = 0;
    int          cnt_eco = 0, cnt_tx = 0;
    logic [11:0] valor_eco;

    int n_checks = 0, n_pass = 0;

    always @(negedge clk) begin
        pronto_medida = 1'b0;
        pronto_tx     = 1'b0;
        if (medir) begin
            n_medir   = n_medir + 1;
            cnt_eco   = eco_on ? c_RESP_ECO : 0;
            valor_eco = ((n_medir - medir_base) % 2 == 1) ? amostra_a : amostra_b;
        end else if (cnt_eco > 0) begin
            cnt_eco = cnt_eco - 1;
            if (cnt_eco == 0) begin
                pronto_medida = 1'b1;
                distancia     = valor_eco;
            end
        end
        if (partida_tx) begin
            if (n_bytes < 256) begin
                byte_mem[n_bytes] = dado_tx;
                pos_mem[n_bytes]  = posicao;
            end
            n_bytes = n_bytes + 1;
            cnt_tx  = c_RESP_TX;
        end else if (cnt_tx > 0) begin
            cnt_tx = cnt_tx - 1;
            if (cnt_tx == 0) pronto_tx = 1'b1;
        end
        if (fim_posicao)   n_fim_pos = n_fim_pos + 1;
        if (fim_varredura) n_fim_var = n_fim_var + 1;
    end

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks = n_checks + 1;
        if (obs === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic ciclo();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [47:0] quadro(input int b);
        logic [47:0] q;
        q = '0;
        if (b >= 0 && b + 5 < 256)
            q = {1'b0, byte_mem[b], 1'b0, byte_mem[b+1], 1'b0, byte_mem[b+2],
                 1'b0, byte_mem[b+3], 1'b0, byte_mem[b+4], 1'b0, byte_mem[b+5]};
        return q;
    endfunction

    task automatic espera_fim_pos(input int alvo, input int limite, input string tag,
                                  output int n_espera);
        int fp0;
        fp0      = n_fim_pos;
        n_espera = 0;
        for (int i = 0; i < limite && (n_fim_pos - fp0) < alvo; i++) begin
            ciclo();
            if (db_estado == 4'd3) n_espera = n_espera + 1;
        end
        check(tag, 48'(n_fim_pos - fp0), 48'(alvo));
    endtask

    task automatic espera_ocioso(input string tag);
        for (int i = 0; i < 10 && db_estado != 4'd0; i++) ciclo();
        check(tag, 48'(db_estado), 48'd0);
    endtask

    initial begin
        int base, fv0, lat, esp, m0, k;

        reset = 1'b0; ligar = 1'b0; modo_continuo = 1'b0;
        eco_on = 1'b1; amostra_a = 12'h123; amostra_b = 12'h045; medir_base = 0;
        distancia = 12'h000; pronto_medida = 1'b0; pronto_tx = 1'b0;
        repeat (3) ciclo();
        check("rst_estado", 48'(db_estado), 48'd0);
        check("rst_dist_min", 48'(distancia_min), 48'h999);
        check("rst_posicao", 48'(posicao), 48'd0);
        check("rst_pulsos", 48'({medir, partida_tx, fim_posicao, fim_varredura, ocupado, alerta}), 48'd0);
        reset = 1'b1;
        ciclo();

        // Single sweep: min(123,045)=045, no alert.
        base = n_bytes; medir_base = n_medir; fv0 = n_fim_var;
        ligar = 1'b1; lat = 0;
        for (int i = 0; i < 100 && n_bytes == base; i++) begin
            ciclo();
            lat = lat + 1;
        end
        // 16-cycle latency counted from the INICIAL cycle that sees ligar,
        // i.e. partida_tx appears on the 15th following negedge.
        check("t1_latencia", 48'(lat), 48'd15);
        for (int i = 0; i < 1000 && n_fim_var == fv0; i++) ciclo();
        check("t1_fim_varredura", 48'(n_fim_var - fv0), 48'd1);
        check("t1_quadro0", quadro(base), "0,045#");
        check("t1_quadro1", quadro(base + 6), "1,045#");
        check("t1_quadro2", quadro(base + 12), "2,045#");
        check("t1_pos_seq", 48'({pos_mem[base], pos_mem[base+6], pos_mem[base+12]}), 48'({2'd0, 2'd1, 2'd2}));
        repeat (3) ciclo();
        check("t1_fim_estado", 48'({db_estado, posicao, ocupado}), 48'({4'd7, 2'd2, 1'b0}));
        check("t1_min_alerta", 48'({distancia_min, alerta}), 48'({12'h045, 1'b0}));
        ligar = 1'b0;
        ciclo();
        check("t1_volta_inicial", 48'({db_estado, posicao}), 48'({4'd0, 2'd0}));

        // Continuous ping-pong: 0,1,2,1,0,1.
        modo_continuo = 1'b1;
        base = n_bytes; medir_base = n_medir; fv0 = n_fim_var;
        ligar = 1'b1;
        espera_fim_pos(6, 3000, "t2_seis_quadros", esp);
        ligar = 1'b0;
        check("t2_pos_seq", 48'({pos_mem[base], pos_mem[base+6], pos_mem[base+12],
                                 pos_mem[base+18], pos_mem[base+24], pos_mem[base+30]}),
              48'({2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd1}));
        check("t2_quadro3", quadro(base + 18), "1,045#");
        check("t2_sem_fim_varredura", 48'(n_fim_var - fv0), 48'd0);
        espera_ocioso("t2_ocioso");

        // Alert: min(019,300)=019 < 020.
        modo_continuo = 1'b0;
        amostra_a = 12'h019; amostra_b = 12'h300;
        base = n_bytes; medir_base = n_medir;
        ligar = 1'b1;
        espera_fim_pos(1, 1000, "t3_quadro_feito", esp);
        ligar = 1'b0;
        check("t3_quadro", quadro(base), "0,019!");
        check("t3_min_alerta", 48'({distancia_min, alerta}), 48'({12'h019, 1'b1}));
        espera_ocioso("t3_ocioso");

        // Timeout on both samples: 2 x 20 cycles in ESPERA.
        eco_on = 1'b0;
        base = n_bytes; medir_base = n_medir;
        ligar = 1'b1;
        espera_fim_pos(1, 1000, "t4_quadro_feito", esp);
        ligar = 1'b0;
        check("t4_ciclos_espera", 48'(esp), 48'd40);
        check("t4_quadro", quadro(base), "0,999#");
        check("t4_min_alerta", 48'({distancia_min, alerta}), 48'({12'h999, 1'b0}));
        espera_ocioso("t4_ocioso");

        // Abort after byte 2 has started.
        eco_on = 1'b1; amostra_a = 12'h123; amostra_b = 12'h045;
        base = n_bytes; medir_base = n_medir;
        ligar = 1'b1;
        for (int i = 0; i < 200 && (n_bytes - base) < 3; i++) ciclo();
        ligar = 1'b0;
        check("t5_tres_bytes", 48'(n_bytes - base), 48'd3);
        k = 0;
        for (int i = 0; i < 20 && !pronto_tx; i++) ciclo();
        check("t5_pronto_tx_visto", 48'(pronto_tx), 48'd1);
        ciclo();
        check("t5_abortado", 48'({db_estado, posicao, ocupado}), 48'({4'd0, 2'd0, 1'b0}));
        repeat (20) ciclo();
        check("t5_sem_partida_extra", 48'(n_bytes - base), 48'd3);
        if (base + 2 < 256) k = int'(byte_mem[base + 2]);
        check("t5_byte2", 48'(k), 48'h30);
        check("t5_min_mantido", 48'({distancia_min, alerta}), 48'({12'h045, 1'b0}));

        // Reset in the ESPERA cycle that carries pronto_medida.
        base = n_bytes; medir_base = n_medir;
        ligar = 1'b1;
        for (int i = 0; i < 100 && !(db_estado == 4'd3 && pronto_medida); i++) ciclo();
        check("t6_gatilho", 48'({db_estado, pronto_medida}), 48'({4'd3, 1'b1}));
        reset = 1'b0;
        ligar = 1'b0;
        m0 = n_medir;
        ciclo();
        check("t6_rst_estado", 48'({db_estado, posicao}), 48'({4'd0, 2'd0}));
        check("t6_rst_min_alerta", 48'({distancia_min, alerta}), 48'({12'h999, 1'b0}));
        check("t6_rst_pulsos", 48'({medir, partida_tx, fim_posicao, fim_varredura, ocupado}), 48'd0);
        repeat (4) ciclo();
        check("t6_sem_medir", 48'(n_medir - m0), 48'd0);
        reset = 1'b1;
        ciclo();
        check("t6_pos_reset", 48'(db_estado), 48'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no completion expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule

`default_nettype wire

// File: doc/sonar_varredura_param.md
Name: sonar_varredura_param

Overview:
Parametrised sweep sequencer for the sonar. It steps the servo through N_POS positions and, at each position, waits for the servo to settle. It then takes N_AMOSTRAS distance measurements through the external measurement unit, keeps the minimum, and sends a 6-byte ASCII frame through the external serial transmitter. It adds single-shot and continuous ping-pong modes, a measurement timeout and a proximity alert. It sits between the sonar top level and the existing measurement, servo-PWM and serial-TX blocks.

Parameters:
N_POS, 8, number of sweep positions (2..16)
T_ASSENTAR, 25_000_000, settle cycles after each servo move (0.5 s @ 50 MHz)
N_AMOSTRAS, 4, measurements per position (1..8)
T_TIMEOUT, 2_500_000, cycles to wait for pronto_medida before declaring no echo
LIMIAR, 12'h020, alert threshold, BCD cm (alert when min < LIMIAR)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
ligar  in  1  run enable, level
modo_continuo  in  1  1 = endless ping-pong sweep; 0 = single sweep 0..N_POS-1
pronto_medida  in  1  1-cycle pulse from measurement unit, distancia valid
distancia  in  12  BCD distance (3 digits)
pronto_tx  in  1  1-cycle pulse: serial byte finished
medir  out  1  1-cycle request to measurement unit
partida_tx  out  1  1-cycle start pulse to serial TX
dado_tx  out  7  ASCII byte, stable from partida_tx until pronto_tx
posicao  out  $clog2(N_POS)  servo position index
distancia_min  out  12  last per-position minimum, BCD
alerta  out  1  registered; 1 if last frame's min < LIMIAR
fim_posicao  out  1  1-cycle pulse after a frame's last byte
fim_varredura  out  1  1-cycle pulse at end of a single sweep
ocupado  out  1  1 in any state except INICIAL/FIM
db_estado  out  4  state encoding

Behaviour:
- Reset (reset==0 at a clock edge): state INICIAL. All outputs 0; distancia_min=12'h999. Direction = up, sample count = 0.
- INICIAL: if ligar==1, go to POSICIONA with posicao=0.
- POSICIONA: the settle counter counts T_ASSENTAR cycles, then goes to MEDE. The running min is loaded with 12'h999 on entry.
- MEDE: medir=1 for exactly one cycle -> ESPERA.
- ESPERA: on pronto_medida, sample = distancia. If T_TIMEOUT cycles elapse first, sample = 12'h999. Either way -> ACUMULA. A pronto_medida outside ESPERA is ignored.
- ACUMULA: min = (sample < min) ? sample : min, compared as unsigned; BCD ordering equals binary ordering for valid digits. Increment the sample count. If count == N_AMOSTRAS, latch distancia_min and alerta (min < LIMIAR), clear count, -> TX. Otherwise -> MEDE.
- TX: sends bytes k=0..5, one at a time. For each byte, partida_tx is pulsed once, then the block waits for pronto_tx before the next byte. Frame contents:
  - byte 0: hex ASCII of posicao ('0'-'9','A'-'F')
  - byte 1: ','
  - bytes 2..4: 7'h30 + hundreds/tens/units digit
  - byte 5: '!' (7'h21) if alerta, else '#' (7'h23)
- After the last pronto_tx: fim_posicao pulse -> PROXIMO.
- PROXIMO:
  - Single mode: if posicao==N_POS-1, pulse fim_varredura and go to FIM; else posicao+1 -> POSICIONA.
  - Continuous mode: ping-pong without repeating endpoints (0,1,..,N-1,N-2,..,0,1,..). Direction flips at 0 and N-1.
- FIM: hold posicao. Return to INICIAL when ligar==0.
- ligar falling mid-operation: if in TX, finish the in-flight byte (wait for pronto_tx), do not start the next byte, then go to INICIAL. From any other state, go to INICIAL on the next edge. In all cases posicao=0, count=0, direction=up. distancia_min and alerta are held.
- modo_continuo is sampled only in PROXIMO; a change mid-sweep takes effect at the next step.
- Simultaneous pronto_medida and timeout expiry in the same cycle: the measured value wins.
- Latency: ligar -> first partida_tx = 1 + T_ASSENTAR + per-sample (2 + response time) + 1 cycles.

Decomposition:
- Package sonar_pkg holds:
  - state enum (INICIAL, POSICIONA, MEDE, ESPERA, ACUMULA, TX, PROXIMO, FIM) with fixed db_estado codes 0..7
  - ASCII constants (ASCII_VIRGULA, ASCII_CERQUILHA, ASCII_EXCLAMACAO, ASCII_ZERO)
  - BCD sentinel SEM_ECO=12'h999
- One natural sub-module, sonar_frame_ascii: combinational mux from (indice_byte, posicao, distancia_min, alerta) to dado_tx.
- Counters are reused from the existing contador_m.

Test Plan:
(Parameters for all scenarios: N_POS=3, T_ASSENTAR=4, N_AMOSTRAS=2, T_TIMEOUT=20, LIMIAR=12'h020.)
1. Reset, single sweep: ligar=1, modo_continuo=0, samples 12'h123/12'h045 at every position -> three frames "0,045#", "1,045#", "2,045#"; posicao 0->1->2; one fim_varredura pulse; FIM until ligar=0.
2. Continuous ping-pong: modo_continuo=1 for 6 frames -> posicao sequence 0,1,2,1,0,1; no fim_varredura.
3. Alert and min: samples 12'h019 then 12'h300 -> distancia_min=12'h019, alerta=1, frame "0,019!".
4. Timeout: no pronto_medida for either sample -> each ESPERA lasts 20 cycles; frame "0,999#", alerta=0.
5. Abort in TX: drop ligar after the partida_tx of byte 2 -> no further partida_tx after pronto_tx. INICIAL within 1 cycle of pronto_tx, posicao=0, ocupado=0.
6. Reset mid-ESPERA with pronto_medida arriving the same cycle -> all outputs are reset values; no medir issued while reset==0.
